uart_rx_parity: RTL and testbench

UART_RX_PARITY -- requirements
Module: uart_rx_parity

---
 rtl/uart_rx_parity.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_parity.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity.sv
// UART receiver, 8 data bits + parity + 1 stop, with valid/ack handshake,
// overrun tracking and break handling (WAIT_HIGH holds until the line recovers).
module uart_rx_parity #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int PARITY        = 0
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       Rx_in,
    input  logic       Rx_ack,
    output logic [7:0] Dout,
    output logic       Rx_valid,
    output logic       Parity_error,
    output logic       Frame_error,
    output logic       Overrun,
    output logic       Busy
);

    localparam int BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic PARITY_BIT = (PARITY != 0);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PAR       = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic             sync1_q, sync2_q;
    logic [1:0]       flush_q, flush_d;
    logic             armed_q, armed_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_err_q, par_err_d;
    logic [7:0]       dout_q, dout_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             rx_s;
    logic             done;

    assign rx_s = sync2_q;

    always_comb begin
        flush_d   = {flush_q[0], 1'b1};
        // A start bit is only accepted once a real (post-reset) high has passed the synchronizer.
        armed_d   = armed_q | (flush_q[1] & rx_s);
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_err_d = par_err_q;
        dout_d    = dout_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PAR;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAR: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (^shreg_q) ^ rx_s ^ PARITY_BIT;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    dout_d  = shreg_q;
                    perr_d  = par_err_q;
                    ferr_d  = !rx_s;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing byte always wins over a simultaneous acknowledge.
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (done) begin
            valid_d = 1'b1;
            if (valid_q && !Rx_ack) begin
                ovr_d = 1'b1;
            end
        end else if (Rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            flush_q   <= '0;
            armed_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_err_q <= 1'b0;
            dout_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= Rx_in;
            sync2_q   <= sync1_q;
            flush_q   <= flush_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_err_q <= par_err_d;
            dout_q    <= dout_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Dout         = dout_q;
    assign Rx_valid     = valid_q;
    assign Parity_error = perr_q;
    assign Frame_error  = ferr_q;
    assign Overrun      = ovr_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Self-checking bench for uart_rx_parity: even- and odd-parity receivers share one
// serial line; expected results come from a frame-level reference model.
module tb_uart_rx_parity;

    localparam int CLKF = 100_000_000;
    localparam int BAUD = 921_600;
    localparam int BIT  = CLKF / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] dout0, dout1;
    logic       v0, pe0, fe0, ov0, b0;
    logic       v1, pe1, fe1, ov1, b1;

    int errors = 0;
    int checks = 0;
    int rises0 = 0;
    logic v0_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        v0_prev <= v0;
        if (v0 && !v0_prev) rises0 <= rises0 + 1;
    end

    uart_rx_parity #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD), .PARITY(0)) dut0 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .Rx_in(rx), .Rx_ack(ack),
        .Dout(dout0), .Rx_valid(v0), .Parity_error(pe0), .Frame_error(fe0),
        .Overrun(ov0), .Busy(b0)
    );

    uart_rx_parity #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD), .PARITY(1)) dut1 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .Rx_in(rx), .Rx_ack(ack),
        .Dout(dout1), .Rx_valid(v1), .Parity_error(pe1), .Frame_error(fe1),
        .Overrun(ov1), .Busy(b1)
    );

    // Reference: error when the count of ones over data, parity bit and mode is odd.
    function automatic logic model_perr(input logic [7:0] d, input logic pbit, input int par);
        return ((($countones(d) + int'(pbit) + par) % 2) != 0);
    endfunction

    function automatic logic even_pbit(input logic [7:0] d);
        return ($countones(d) % 2) != 0;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        cycles(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b0;
        cycles(3);
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected %h", dout0, 8'h00); end
        checks++; if ({v0, pe0, fe0, ov0, b0} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected %b", {v0, pe0, fe0, ov0, b0}, 5'b0); end
        rst_n = 1'b1;
        cycles(3 * BIT);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_low_line_busy: got %b expected %b", b0, 1'b0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_low_line_valid: got %b expected %b", v0, 1'b0); end
        rx = 1'b1;
        cycles(20);
    endtask

    task automatic test_basic();
        logic [7:0] d = 8'h5A;
        send_frame(d, even_pbit(d), 1'b1);
        cycles(10);
        checks++; if (dout0 !== d) begin errors++; $display("FAIL basic_dout: got %h expected %h", dout0, d); end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected %b", v0, 1'b1); end
        checks++; if (pe0 !== model_perr(d, even_pbit(d), 0)) begin errors++; $display("FAIL basic_perr_even: got %b expected %b", pe0, model_perr(d, even_pbit(d), 0)); end
        checks++; if (pe1 !== model_perr(d, even_pbit(d), 1)) begin errors++; $display("FAIL basic_perr_odd: got %b expected %b", pe1, model_perr(d, even_pbit(d), 1)); end
        checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected %b", fe0, 1'b0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected %b", b0, 1'b0); end
        pulse_ack();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_ack_valid: got %b expected %b", v0, 1'b0); end
        checks++; if (dout0 !== d) begin errors++; $display("FAIL basic_ack_dout_hold: got %h expected %h", dout0, d); end
    endtask

    task automatic test_parity();
        logic [7:0] d = 8'h5A;
        send_frame(d, 1'b1, 1'b1);
        cycles(10);
        checks++; if (dout0 !== d) begin errors++; $display("FAIL parity_dout: got %h expected %h", dout0, d); end
        checks++; if (pe0 !== model_perr(d, 1'b1, 0)) begin errors++; $display("FAIL parity_even_mode: got %b expected %b", pe0, model_perr(d, 1'b1, 0)); end
        checks++; if (pe1 !== model_perr(d, 1'b1, 1)) begin errors++; $display("FAIL parity_odd_mode: got %b expected %b", pe1, model_perr(d, 1'b1, 1)); end
        pulse_ack();
    endtask

    task automatic test_frame_error();
        logic [7:0] d = 8'h41;
        int r0;
        r0 = rises0;
        send_frame(d, even_pbit(d), 1'b0);
        cycles(3 * BIT);
        checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL frame_ferr: got %b expected %b", fe0, 1'b1); end
        checks++; if (dout0 !== d) begin errors++; $display("FAIL frame_dout: got %h expected %h", dout0, d); end
        checks++; if (rises0 - r0 !== 1) begin errors++; $display("FAIL frame_completions: got %0d expected %0d", rises0 - r0, 1); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL frame_busy_break: got %b expected %b", b0, 1'b1); end
        rx = 1'b1;
        cycles(5);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL frame_busy_release: got %b expected %b", b0, 1'b0); end
        pulse_ack();
        cycles(20);
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        logic v;
        d = dout0;
        v = v0;
        rx = 1'b0;
        cycles(BIT / 5);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected %b", b0, 1'b1); end
        rx = 1'b1;
        cycles(BIT);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected %b", b0, 1'b0); end
        checks++; if (dout0 !== d) begin errors++; $display("FAIL glitch_dout: got %h expected %h", dout0, d); end
        checks++; if (v0 !== v) begin errors++; $display("FAIL glitch_valid: got %b expected %b", v0, v); end
    endtask

    task automatic test_overrun();
        send_frame(8'h31, even_pbit(8'h31), 1'b1);
        cycles(20);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL overrun_first: got %b expected %b", ov0, 1'b0); end
        send_frame(8'h32, even_pbit(8'h32), 1'b1);
        cycles(10);
        checks++; if (dout0 !== 8'h32) begin errors++; $display("FAIL overrun_dout: got %h expected %h", dout0, 8'h32); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected %b", ov0, 1'b1); end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected %b", v0, 1'b1); end
        pulse_ack();
        checks++; if ({v0, ov0} !== 2'b00) begin errors++; $display("FAIL overrun_ack: got %b expected %b", {v0, ov0}, 2'b00); end
        checks++; if (dout0 !== 8'h32) begin errors++; $display("FAIL overrun_ack_dout: got %h expected %h", dout0, 8'h32); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        cycles(BIT / 2);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected %b", b0, 1'b1); end
        rst_n = 1'b0;
        #1;
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %h expected %h", dout0, 8'h00); end
        checks++; if ({v0, pe0, fe0, ov0, b0} !== 5'b0) begin errors++; $display("FAIL midreset_flags: got %b expected %b", {v0, pe0, fe0, ov0, b0}, 5'b0); end
        cycles(2);
        rx = 1'b1;
        rst_n = 1'b1;
        cycles(2 * BIT);
        send_frame(d, even_pbit(d), 1'b1);
        cycles(10);
        checks++; if (dout0 !== d) begin errors++; $display("FAIL midreset_next_dout: got %h expected %h", dout0, d); end
        checks++; if ({v0, pe0, fe0, ov0} !== 4'b1000) begin errors++; $display("FAIL midreset_next_flags: got %b expected %b", {v0, pe0, fe0, ov0}, 4'b1000); end
        pulse_ack();
    endtask

    task automatic test_random();
        logic exp_valid = 1'b0;
        logic exp_ovr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            logic pbit, stop, do_ack;
            d      = 8'($urandom_range(0, 255));
            pbit   = 1'($urandom_range(0, 1));
            stop   = ($urandom_range(0, 3) != 0);
            do_ack = 1'($urandom_range(0, 1));
            send_frame(d, pbit, stop);
            rx = 1'b1;
            cycles(20);
            exp_ovr   = exp_ovr | exp_valid;
            exp_valid = 1'b1;
            checks++; if (dout0 !== d) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", k, dout0, d); end
            checks++; if (pe0 !== model_perr(d, pbit, 0)) begin errors++; $display("FAIL rand_perr_even[%0d]: got %b expected %b", k, pe0, model_perr(d, pbit, 0)); end
            checks++; if (pe1 !== model_perr(d, pbit, 1)) begin errors++; $display("FAIL rand_perr_odd[%0d]: got %b expected %b", k, pe1, model_perr(d, pbit, 1)); end
            checks++; if (fe0 !== !stop) begin errors++; $display("FAIL rand_ferr[%0d]: got %b expected %b", k, fe0, !stop); end
            checks++; if ({v0, ov0} !== {exp_valid, exp_ovr}) begin errors++; $display("FAIL rand_valid_ovr[%0d]: got %b expected %b", k, {v0, ov0}, {exp_valid, exp_ovr}); end
            checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", k, b0, 1'b0); end
            if (do_ack) begin
                pulse_ack();
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
            end
        end
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
